// File: rtl/cim_core_macro_mem_router.sv
// Routes one upstream memory port onto NB_MACROS macro ports by address decode; misses answer with err.
// Latency: request/grant combinational, response exactly RD_LATENCY cycles after acceptance, in order.
// Backpressure: upstream stalls only while the addressed macro withholds its grant; the response path never stalls.
module cim_core_macro_mem_router #(
    parameter int unsigned               NB_MACROS      = 9,
    parameter int unsigned               MEM_ADDR_WIDTH = 32,
    parameter int unsigned               MEM_DATA_WIDTH = 64,
    parameter logic [MEM_ADDR_WIDTH-1:0] BASE_ADDR      = '0,
    parameter int unsigned               MACRO_SIZE     = 32'h1000,
    parameter int unsigned               RD_LATENCY     = 1,
    parameter int unsigned               LOCAL_AW       = $clog2(MACRO_SIZE)
) (
    input  logic                                         clk_i,
    input  logic                                         rst_ni,
    input  logic                                         req_i,
    output logic                                         gnt_o,
    input  logic                                         we_i,
    input  logic [MEM_ADDR_WIDTH-1:0]                    addr_i,
    input  logic [MEM_DATA_WIDTH/8-1:0]                  be_i,
    input  logic [MEM_DATA_WIDTH-1:0]                    wdata_i,
    output logic                                         rvalid_o,
    output logic [MEM_DATA_WIDTH-1:0]                    rdata_o,
    output logic                                         err_o,
    output logic                                         busy_o,
    output logic [NB_MACROS-1:0]                         macro_req_o,
    input  logic [NB_MACROS-1:0]                         macro_gnt_i,
    output logic                                         macro_we_o,
    output logic [LOCAL_AW-1:0]                          macro_addr_o,
    output logic [MEM_DATA_WIDTH/8-1:0]                  macro_be_o,
    output logic [MEM_DATA_WIDTH-1:0]                    macro_wdata_o,
    input  logic [NB_MACROS-1:0][MEM_DATA_WIDTH-1:0]     macro_rdata_i
);

    localparam int unsigned IDX_W = (NB_MACROS > 1) ? $clog2(NB_MACROS) : 1;
    localparam int unsigned CNT_W = $clog2(RD_LATENCY + 1) + 1;
    localparam int unsigned AW1   = MEM_ADDR_WIDTH + 1;
    localparam logic [AW1-1:0] END_ADDR = AW1'(BASE_ADDR) + AW1'(NB_MACROS * MACRO_SIZE);

    typedef struct packed {
        logic             vld;
        logic             rd;
        logic             err;
        logic [IDX_W-1:0] idx;
    } rsp_t;

    logic                      below_base;
    logic [MEM_ADDR_WIDTH-1:0] off;
    logic                      hit;
    logic [NB_MACROS-1:0]      sel;
    logic [IDX_W-1:0]          idx;
    logic                      accept;
    rsp_t                      push;
    rsp_t                      pipe [RD_LATENCY];
    rsp_t                      last;
    logic [CNT_W-1:0]          cnt;

    // The borrow of the base subtraction flags addresses below the window, so no wrap-around can alias in.
    assign {below_base, off} = {1'b0, addr_i} - {1'b0, BASE_ADDR};
    assign hit = !below_base && ({1'b0, addr_i} < END_ADDR);

    always_comb begin
        sel = '0;
        idx = '0;
        for (int i = 0; i < int'(NB_MACROS); i++) begin
            if (hit && ((off >> LOCAL_AW) == MEM_ADDR_WIDTH'(i))) begin
                sel[i] = 1'b1;
                idx    = IDX_W'(i);
            end
        end
    end

    assign macro_req_o   = req_i ? sel : '0;
    assign macro_addr_o  = off[LOCAL_AW-1:0];
    assign macro_we_o    = req_i && hit && we_i;
    assign macro_be_o    = (req_i && hit) ? be_i : '0;
    assign macro_wdata_o = (req_i && hit) ? wdata_i : '0;

    assign gnt_o  = req_i && (hit ? |(sel & macro_gnt_i) : 1'b1);
    assign accept = req_i && gnt_o;

    always_comb begin
        push     = '0;
        push.vld = accept;
        push.rd  = accept && !we_i;
        push.err = accept && !hit;
        push.idx = accept ? idx : '0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int k = 0; k < int'(RD_LATENCY); k++) begin
                pipe[k] <= '0;
            end
        end else begin
            pipe[0] <= push;
            for (int k = 1; k < int'(RD_LATENCY); k++) begin
                pipe[k] <= pipe[k-1];
            end
        end
    end

    assign last     = pipe[RD_LATENCY-1];
    assign rvalid_o = last.vld;
    assign err_o    = last.err;

    always_comb begin
        rdata_o = '0;
        if (last.vld && last.rd && !last.err) begin
            for (int i = 0; i < int'(NB_MACROS); i++) begin
                if (last.idx == IDX_W'(i)) begin
                    rdata_o = macro_rdata_i[i];
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt <= '0;
        end else begin
            case ({accept, last.vld})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    assign busy_o = (cnt != '0);

    cnt_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(accept && !last.vld && (cnt == CNT_W'(RD_LATENCY))));
    cnt_no_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(last.vld && !accept && (cnt == '0)));
    cnt_bounded: assert property (@(posedge clk_i) disable iff (!rst_ni)
        cnt <= CNT_W'(RD_LATENCY));
    // The router keeps no copy of a stalled request, so the master must hold it.
    req_held_while_stalled: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (req_i && !gnt_o) |=> (req_i && $stable({we_i, addr_i, be_i, wdata_i})));

endmodule

// File: tb/tb_cim_core_macro_mem_router.sv
// Randomized and directed bench for the macro memory router, scoreboarded against an address-map model.
module tb_cim_core_macro_mem_router;

    localparam int          NB    = 9;
    localparam int          AW    = 32;
    localparam int          DW    = 64;
    localparam int          LAT   = 3;
    localparam int unsigned MSIZE = 32'h1000;
    localparam logic [31:0] BASE  = 32'h0;

    logic                   clk_i = 1'b0;
    logic                   rst_ni;
    logic                   req_i;
    logic                   gnt_o;
    logic                   we_i;
    logic [AW-1:0]          addr_i;
    logic [DW/8-1:0]        be_i;
    logic [DW-1:0]          wdata_i;
    logic                   rvalid_o;
    logic [DW-1:0]          rdata_o;
    logic                   err_o;
    logic                   busy_o;
    logic [NB-1:0]          macro_req_o;
    logic [NB-1:0]          macro_gnt_i;
    logic                   macro_we_o;
    logic [11:0]            macro_addr_o;
    logic [DW/8-1:0]        macro_be_o;
    logic [DW-1:0]          macro_wdata_o;
    logic [NB-1:0][DW-1:0]  macro_rdata_i;

    cim_core_macro_mem_router #(
        .NB_MACROS(NB), .MEM_ADDR_WIDTH(AW), .MEM_DATA_WIDTH(DW),
        .BASE_ADDR(BASE), .MACRO_SIZE(MSIZE), .RD_LATENCY(LAT)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .gnt_o(gnt_o), .we_i(we_i),
        .addr_i(addr_i), .be_i(be_i), .wdata_i(wdata_i), .rvalid_o(rvalid_o),
        .rdata_o(rdata_o), .err_o(err_o), .busy_o(busy_o), .macro_req_o(macro_req_o),
        .macro_gnt_i(macro_gnt_i), .macro_we_o(macro_we_o), .macro_addr_o(macro_addr_o),
        .macro_be_o(macro_be_o), .macro_wdata_o(macro_wdata_o), .macro_rdata_i(macro_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    // Each macro presents a cycle-stamped word, so the expected read data pins down both macro and cycle.
    function automatic logic [63:0] mdata(int i, int c);
        return {8'(i), 24'hC0FFEE, 32'(c)};
    endfunction

    always_comb begin
        for (int i = 0; i < NB; i++) macro_rdata_i[i] = mdata(i, cyc);
    end

    function automatic bit m_hit(logic [31:0] a);
        longint x = longint'({32'h0, a});
        return (x >= longint'({32'h0, BASE})) && (x < longint'({32'h0, BASE}) + longint'(NB) * longint'(MSIZE));
    endfunction

    function automatic int m_idx(logic [31:0] a);
        return int'((a - BASE) / MSIZE);
    endfunction

    function automatic logic [63:0] m_local(logic [31:0] a);
        return 64'((a - BASE) % MSIZE);
    endfunction

    typedef struct {
        int          acc;
        int          due;
        bit          err;
        logic [63:0] data;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic do_txn(input logic [31:0] a, input bit we, input logic [7:0] be,
                          input logic [63:0] wd, input int stall);
        bit            h  = m_hit(a);
        int            ix = m_idx(a);
        int            waited = 0;
        bit            done = 0;
        bit            egnt;
        logic [NB-1:0] ereq;
        exp_t          e;
        req_i = 1'b1; we_i = we; addr_i = a; be_i = be; wdata_i = wd;
        while (!done) begin
            macro_gnt_i = NB'($urandom);
            if (h) macro_gnt_i[ix] = (waited >= stall);
            #2;
            ereq = '0;
            if (h) ereq[ix] = 1'b1;
            egnt = h ? (waited >= stall) : 1'b1;
            chk("macro_req", 64'(macro_req_o), 64'(ereq));
            chk("gnt", 64'(gnt_o), 64'(egnt));
            chk("macro_addr", 64'(macro_addr_o), m_local(a));
            chk("macro_we", 64'(macro_we_o), h ? 64'(we) : 64'h0);
            chk("macro_be", 64'(macro_be_o), h ? 64'(be) : 64'h0);
            chk("macro_wdata", macro_wdata_o, h ? wd : 64'h0);
            if (egnt) begin
                e.acc  = cyc;
                e.due  = cyc + LAT;
                e.err  = !h;
                e.data = (h && !we) ? mdata(ix, cyc + LAT) : 64'h0;
                q.push_back(e);
            end
            done = egnt;
            @(posedge clk_i); #1;
            waited++;
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            req_i = 1'b0;
            macro_gnt_i = NB'($urandom);
            #2;
            chk("idle_macro_req", 64'(macro_req_o), 64'h0);
            chk("idle_gnt", 64'(gnt_o), 64'h0);
            @(posedge clk_i); #1;
        end
    endtask

    // Monitor: pops the oldest expectation whenever a response shows up, and flags late or stray ones.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_i);
            if (rst_ni) begin
                chk("busy", 64'(busy_o), 64'((q.size() > 0) && (q[0].acc < cyc)));
                while ((q.size() > 0) && (q[0].due < cyc)) begin
                    checks++; errors++;
                    $display("FAIL rsp_missing: no response by cycle %0d, required at cycle %0d", cyc, q[0].due);
                    void'(q.pop_front());
                end
                if (rvalid_o) begin
                    if (q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL rsp_unexpected: rvalid_o=1 at cycle %0d, required no response", cyc);
                    end else begin
                        e = q.pop_front();
                        chk("rsp_cycle", 64'(cyc), 64'(e.due));
                        chk("rsp_err", 64'(err_o), 64'(e.err));
                        chk("rsp_rdata", rdata_o, e.data);
                    end
                end else begin
                    chk("idle_err", 64'(err_o), 64'h0);
                    chk("idle_rdata", rdata_o, 64'h0);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        rst_ni = 1'b0; req_i = 1'b0; we_i = 1'b0; addr_i = '0; be_i = '0; wdata_i = '0;
        macro_gnt_i = '1;
        repeat (3) @(posedge clk_i);
        #1;
        chk("reset_rvalid", 64'(rvalid_o), 64'h0);
        chk("reset_err", 64'(err_o), 64'h0);
        chk("reset_busy", 64'(busy_o), 64'h0);
        chk("reset_rdata", rdata_o, 64'h0);
        #1 rst_ni = 1'b1;

        // Directed vectors, the first one landing on the first edge after reset release.
        do_txn(32'h2010, 1'b1, 8'hFF, 64'hA5A5A5A5A5A5A5A5, 0);
        do_txn(32'h8FF8, 1'b0, 8'hFF, 64'h0, 0);
        do_txn(32'h9000, 1'b0, 8'hFF, 64'h0, 0);
        do_txn(32'h3000, 1'b0, 8'hFF, 64'h0, 3);
        idle(1);
        do_txn(32'h8FFF, 1'b0, 8'h01, 64'h0, 0);
        do_txn(32'h9000, 1'b1, 8'h0F, 64'h1122334455667788, 0);
        do_txn(32'hFFFF_FFFF, 1'b0, 8'hFF, 64'h0, 0);
        do_txn(32'h0000, 1'b0, 8'hFF, 64'h0, 0);
        do_txn(32'h1000, 1'b0, 8'hFF, 64'h0, 0);
        do_txn(32'h0008, 1'b0, 8'hFF, 64'h0, 0);
        idle(LAT + 1);

        // Two reads in flight, then an asynchronous reset pulse.
        do_txn(32'h4000, 1'b0, 8'hFF, 64'h0, 0);
        do_txn(32'h5008, 1'b0, 8'hFF, 64'h0, 0);
        req_i = 1'b0;
        #1 rst_ni = 1'b0;
        #1;
        chk("midrst_rvalid", 64'(rvalid_o), 64'h0);
        chk("midrst_busy", 64'(busy_o), 64'h0);
        chk("midrst_err", 64'(err_o), 64'h0);
        chk("midrst_rdata", rdata_o, 64'h0);
        q.delete();
        @(posedge clk_i); #2;
        rst_ni = 1'b1;
        @(posedge clk_i); #1;
        idle(LAT + 2);

        for (int n = 0; n < 300; n++) begin
            case ($urandom_range(0, 9))
                0:       a = $urandom;
                1:       a = 32'(NB) * MSIZE - 32'($urandom_range(0, 1));
                2:       a = 32'hFFFF_FFFF;
                default: a = 32'($urandom_range(0, NB * MSIZE - 1));
            endcase
            do_txn(a, 1'($urandom), 8'($urandom), {$urandom, $urandom},
                   ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0);
            if ($urandom_range(0, 4) == 0) idle(1);
        end
        idle(LAT + 3);
        chk("drain_empty", 64'(q.size()), 64'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
